// File: rtl/sparrow_dmem_responder.sv
// sparrow_dmem_responder
// Memory-side end of the sparrow core load/store port. Accepts one access
// at a time, holds it LATENCY cycles, then pulses data_rvalid_o for a cycle.
// Stores commit byte/half/word lanes into an internal word array. Loads
// return right-justified, zero-filled data.
//
// Optional feature: define SPARROW_DMEM_ERR_EN to flag misaligned, illegal
// size or out-of-range accesses on data_err_o (store suppressed, rdata 0).
// Without it, data_err_o is 0, addresses are forced aligned, size 2'b10 acts
// as word and the word index wraps modulo DEPTH_WORDS.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   data_req_i       access request, held stable until data_rvalid_o
//   data_wr_i        1 = store, 0 = load
//   data_byte_i      size: 00 byte, 01 half, 11 word, 10 illegal
//   data_addr_i      byte address
//   data_wdata_i     right-justified store data
//   data_ready_o     idle, can accept this cycle
//   data_rvalid_o    one-cycle response pulse
//   data_rdata_o     right-justified load data (0 for stores)
//   data_err_o       error flag, valid with data_rvalid_o
module sparrow_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_byte_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_ready_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [1:0]     size_q;
    logic           wr_q;

    logic [31:0]    mem [DEPTH_WORDS];

    // Read-side access fields: live inputs when RESP is entered straight
    // from IDLE (LATENCY == 1), otherwise the captured request.
    logic [31:0]    rd_addr;
    logic [1:0]     rd_size;
    logic           rd_wr;
    logic [31:0]    rd_word;
    logic [31:0]    rd_data;
    logic           rd_err;

    // Byte-lane extraction of a load, right-justified and zero-filled.
    function automatic logic [31:0] lane_extract(input logic [31:0] w,
                                                 input logic [1:0]  sz,
                                                 input logic [1:0]  ln);
        case (sz)
            2'b00:   return {24'b0, w[{ln, 3'b000} +: 8]};
            2'b01:   return {16'b0, w[{ln[1], 4'b0000} +: 16]};
            default: return w;
        endcase
    endfunction

    always_comb begin
        rd_addr = addr_q;
        rd_size = size_q;
        rd_wr   = wr_q;
        if (state == IDLE) begin
            rd_addr = data_addr_i;
            rd_size = data_byte_i;
            rd_wr   = data_wr_i;
        end
    end

    assign rd_word = mem[rd_addr[AW+1:2]];
    assign rd_data = lane_extract(rd_word, rd_size, rd_addr[1:0]);

`ifdef SPARROW_DMEM_ERR_EN
    logic rd_misaligned;
    logic rd_illegal;
    logic rd_oob;

    // Error classification of the access being responded to.
    always_comb begin
        rd_misaligned = 1'b0;
        rd_illegal    = 1'b0;
        case (rd_size)
            2'b00:   rd_misaligned = 1'b0;
            2'b01:   rd_misaligned = rd_addr[0];
            2'b11:   rd_misaligned = |rd_addr[1:0];
            default: rd_illegal    = 1'b1;
        endcase
    end

    assign rd_oob = (rd_addr >> (AW + 2)) != 32'd0;
    assign rd_err = rd_misaligned | rd_illegal | rd_oob;
`else
    logic unused_hi;

    // Upper address bits only matter for the range check.
    assign unused_hi  = ^{rd_addr[31:AW+2], addr_q[31:AW+2]};
    assign rd_err     = 1'b0;
    assign data_err_o = 1'b0;
`endif

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            size_q        <= '0;
            wr_q          <= 1'b0;
            data_ready_o  <= 1'b1;
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
`ifdef SPARROW_DMEM_ERR_EN
            data_err_o    <= 1'b0;
`endif
        end else begin
            data_rvalid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_req_i) begin
                        addr_q       <= data_addr_i;
                        wdata_q      <= data_wdata_i;
                        size_q       <= data_byte_i;
                        wr_q         <= data_wr_i;
                        cnt          <= CW'(LATENCY - 1);
                        data_ready_o <= 1'b0;
                        if (LATENCY == 1) begin
                            state         <= RESP;
                            data_rvalid_o <= 1'b1;
                            data_rdata_o  <= (rd_wr || rd_err) ? 32'd0 : rd_data;
`ifdef SPARROW_DMEM_ERR_EN
                            data_err_o    <= rd_err;
`endif
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Counter reaches zero on the edge that enters RESP.
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        cnt           <= '0;
                        state         <= RESP;
                        data_rvalid_o <= 1'b1;
                        data_rdata_o  <= (rd_wr || rd_err) ? 32'd0 : rd_data;
`ifdef SPARROW_DMEM_ERR_EN
                        data_err_o    <= rd_err;
`endif
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    data_ready_o <= 1'b1;
                end
                default: begin
                    state        <= IDLE;
                    data_ready_o <= 1'b1;
                end
            endcase
        end
    end

    // Store lane enables and lane-replicated store data.
    logic [3:0]  wr_be;
    logic [31:0] wr_data;

    always_comb begin
        wr_be   = 4'b1111;
        wr_data = wdata_q;
        case (size_q)
            2'b00: begin
                wr_be   = 4'b0001 << addr_q[1:0];
                wr_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata_q[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = wdata_q;
            end
        endcase
    end

    // Store commits on the edge leaving RESP; a reset returns to IDLE first.
    always_ff @(posedge clk) begin
        if (state == RESP && wr_q && !data_err_o) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[addr_q[AW+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sparrow_dmem_responder.sv
// Testbench for sparrow_dmem_responder: two instances (LATENCY 1 and 4), each
// with a driver that pushes expected responses from a byte-addressed
// reference memory and a monitor that pops and compares on data_rvalid_o.
module tb_sparrow_dmem_responder;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned NBYTES = 4 * DEPTH;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int unsigned LAT = (g == 0) ? 1 : 4;

        logic        reset;
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;

        int   passed = 0;
        int   total  = 0;
        bit   done   = 1'b0;
        exp_t q[$];
        logic [7:0] ref_mem [NBYTES];

        sparrow_dmem_responder #(
            .DEPTH_WORDS (DEPTH),
            .LATENCY     (LAT)
        ) dut (
            .clk           (clk),
            .reset         (reset),
            .data_req_i    (req),
            .data_wr_i     (wr),
            .data_byte_i   (size),
            .data_addr_i   (addr),
            .data_wdata_i  (wdata),
            .data_ready_o  (ready),
            .data_rvalid_o (rvalid),
            .data_rdata_o  (rdata),
            .data_err_o    (err)
        );

        task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
            total++;
            if (act !== exp)
                $display("FAIL %s (LATENCY=%0d): got %h expected %h", name, LAT, act, exp);
            else
                passed++;
        endtask

        // Reference: little-endian byte memory, access rules applied directly.
        task automatic model(input logic w, input logic [1:0] s, input logic [31:0] a,
                             input logic [31:0] d, output exp_t e);
            int unsigned n;
            int unsigned ba;
            bit bad;
            n   = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
            bad = 1'b0;
`ifdef SPARROW_DMEM_ERR_EN
            bad = (s == 2'b10) || (a % n != 0) || (a >= NBYTES);
            ba  = a;
`else
            ba  = (a - a % n) % NBYTES;
`endif
            e.rdata = '0;
            e.err   = bad;
            if (!bad) begin
                for (int i = 0; i < int'(n); i++) begin
                    if (w) ref_mem[ba + i] = d[8*i +: 8];
                    else   e.rdata[8*i +: 8] = ref_mem[ba + i];
                end
            end
        endtask

        task automatic issue(input logic w, input logic [1:0] s, input logic [31:0] a,
                             input logic [31:0] d, input bit hold);
            exp_t e;
            int   n;
            bit   seen;
            bit   rdy_bad;
            n = 0;
            while (!ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("ready_before_accept", 32'(ready), 32'd1);
            req = 1'b1; wr = w; size = s; addr = a; wdata = d;
            model(w, s, a, d, e);
            q.push_back(e);
            @(posedge clk);
            n = 0; seen = 1'b0; rdy_bad = 1'b0;
            while (!seen && n < 20) begin
                @(negedge clk);
                n++;
                if (ready) rdy_bad = 1'b1;
                if (rvalid) seen = 1'b1;
                else if (!hold) req = 1'b0;
            end
            check("rvalid_latency", 32'(n), 32'(LAT));
            check("ready_low_while_busy", 32'(rdy_bad), 32'd0);
            req = 1'b0;
            @(negedge clk);
            check("rvalid_single_pulse", 32'(rvalid), 32'd0);
            check("ready_after_resp", 32'(ready), 32'd1);
        endtask

        // Store that is killed by reset k edges after accept (in WAIT or RESP).
        task automatic abort_store(input logic [31:0] a, input logic [31:0] d, input int k);
            while (!ready) @(negedge clk);
            req = 1'b1; wr = 1'b1; size = 2'b11; addr = a; wdata = d;
            @(posedge clk);
            repeat (k) @(posedge clk);
            #2;
            reset = 1'b1;
            req   = 1'b0;
            #1;
            check("reset_rvalid", 32'(rvalid), 32'd0);
            check("reset_ready", 32'(ready), 32'd1);
            check("reset_rdata", rdata, 32'd0);
            check("reset_err", 32'(err), 32'd0);
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
        endtask

        initial begin
            reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; addr = '0; wdata = '0;
            fork
                begin : driver
                    repeat (3) @(negedge clk);
                    check("por_ready", 32'(ready), 32'd1);
                    check("por_rvalid", 32'(rvalid), 32'd0);
                    check("por_rdata", rdata, 32'd0);
                    check("por_err", 32'(err), 32'd0);
                    reset = 1'b0;
                    @(negedge clk);

                    for (int w = 0; w < int'(DEPTH); w++) issue(1'b1, 2'b11, 32'(4 * w), 32'd0, 1'b1);

                    issue(1'b1, 2'b11, 32'h10, 32'hDEADBEEF, 1'b1);
                    issue(1'b0, 2'b11, 32'h10, 32'd0, 1'b1);
                    check("plan_word_load", rdata, 32'hDEADBEEF);
                    issue(1'b1, 2'b11, 32'h10, 32'h0, 1'b0);
                    issue(1'b1, 2'b00, 32'h11, 32'hAA, 1'b1);
                    issue(1'b0, 2'b11, 32'h10, 32'd0, 1'b1);
                    check("plan_byte_in_word", rdata, 32'h0000AA00);
                    issue(1'b0, 2'b00, 32'h11, 32'd0, 1'b0);
                    check("plan_byte_load", rdata, 32'h000000AA);
                    issue(1'b1, 2'b01, 32'h22, 32'h1234, 1'b1);
                    issue(1'b0, 2'b01, 32'h22, 32'd0, 1'b1);
                    check("plan_half_load", rdata, 32'h00001234);
                    issue(1'b0, 2'b11, 32'h20, 32'd0, 1'b1);
                    check("plan_half_in_word", rdata, 32'h12340000);
                    issue(1'b1, 2'b11, 32'h13, 32'hCAFEF00D, 1'b1);
                    issue(1'b0, 2'b11, 32'h10, 32'd0, 1'b1);
`ifdef SPARROW_DMEM_ERR_EN
                    check("plan_misaligned_store", rdata, 32'h0000AA00);
`else
                    check("plan_misaligned_store", rdata, 32'hCAFEF00D);
`endif
                    issue(1'b1, 2'b11, 32'h40, 32'h0BADCAFE, 1'b1);
                    abort_store(32'h40, 32'h55555555, (LAT == 1) ? 0 : 1);
                    issue(1'b0, 2'b11, 32'h40, 32'd0, 1'b1);
                    check("plan_reset_drops_store", rdata, 32'h0BADCAFE);

                    for (int i = 0; i < 150; i++) begin
                        logic [31:0] a;
                        if ($urandom_range(0, 9) == 0) a = $urandom;
                        else a = 32'($urandom_range(0, 2 * NBYTES - 1));
                        issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a,
                              $urandom, 1'($urandom_range(0, 1)));
                    end

                    repeat (3) @(negedge clk);
                    check("queue_drained", 32'(q.size()), 32'd0);
                    done = 1'b1;
                end
                begin : monitor
                    exp_t e;
                    while (!done) begin
                        @(negedge clk);
                        if (rvalid) begin
                            if (q.size() == 0) begin
                                check("unexpected_rvalid", 32'd1, 32'd0);
                            end else begin
                                e = q.pop_front();
                                check("rdata", rdata, e.rdata);
                                check("err", 32'(err), 32'(e.err));
                            end
                        end
                    end
                end
            join
        end
    end

    int timeout_fail = 0;

    initial begin
        int t;
        t = 0;
        while (!(lane[0].done && lane[1].done) && t < 50000) begin
            @(negedge clk);
            t++;
        end
        if (!(lane[0].done && lane[1].done)) begin
            $display("FAIL timeout: done flags %0d %0d required 1 1", lane[0].done, lane[1].done);
            timeout_fail = 1;
        end
        $display("%0d/%0d checks passed", lane[0].passed + lane[1].passed,
                 lane[0].total + lane[1].total + timeout_fail);
        $finish;
    end

endmodule
